// File: rtl/friscv_apb_arbiter.sv
// Round-robin arbiter sharing one APB-like slave port between NB_MST requesters.
// Registered request forwarding, completion pulse and a per-access timeout.
module friscv_apb_arbiter #(
    parameter int NB_MST  = 2,
    parameter int ADDRW   = 16,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
)(
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     srst,
    input  logic [NB_MST-1:0]        mst_en,
    input  logic [NB_MST-1:0]        mst_wr,
    input  logic [NB_MST*ADDRW-1:0]  mst_addr,
    input  logic [NB_MST*XLEN-1:0]   mst_wdata,
    input  logic [NB_MST*XLEN/8-1:0] mst_strb,
    output logic [NB_MST-1:0]        mst_ready,
    output logic [XLEN-1:0]          mst_rdata,
    output logic                     mst_err,
    output logic                     slv_en,
    output logic                     slv_wr,
    output logic [ADDRW-1:0]         slv_addr,
    output logic [XLEN-1:0]          slv_wdata,
    output logic [XLEN/8-1:0]        slv_strb,
    input  logic [XLEN-1:0]          slv_rdata,
    input  logic                     slv_ready
);

    localparam int STRBW = XLEN / 8;
    localparam int PTRW  = (NB_MST > 1) ? $clog2(NB_MST) : 1;
    localparam int SUMW  = PTRW + 1;
    localparam int CNTW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNTW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    state_t            state;
    state_t            nxt_state;
    logic [PTRW-1:0]   ptr;
    logic [PTRW-1:0]   grant;
    logic [CNTW-1:0]   counter;

    logic              found;
    logic [PTRW-1:0]   win;
    logic [SUMW-1:0]   sum;
    logic              sel_wr;
    logic [ADDRW-1:0]  sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic [STRBW-1:0]  sel_strb;
    logic              timed_out;

    // Scan requesters starting at ptr, wrapping, first active one wins
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < NB_MST; i++) begin
            sum = {1'b0, ptr} + SUMW'(i);
            if (sum >= SUMW'(NB_MST))
                sum = sum - SUMW'(NB_MST);
            if (!found && mst_en[sum[PTRW-1:0]]) begin
                found = 1'b1;
                win   = sum[PTRW-1:0];
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        for (int i = 0; i < NB_MST; i++) begin
            if (win == PTRW'(i)) begin
                sel_wr    = mst_wr[i];
                sel_addr  = mst_addr[i*ADDRW +: ADDRW];
                sel_wdata = mst_wdata[i*XLEN +: XLEN];
                sel_strb  = mst_strb[i*STRBW +: STRBW];
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && (counter == CNT_LAST);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else if (srst)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        unique case (state)
            IDLE:     if (found) nxt_state = ACCESS;
            ACCESS:   if (slv_ready || timed_out) nxt_state = COMPLETE;
            COMPLETE: nxt_state = IDLE;
            default:  nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr       <= '0;
            grant     <= '0;
            counter   <= '0;
            slv_en    <= 1'b0;
            slv_wr    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_strb  <= '0;
            mst_ready <= '0;
            mst_rdata <= '0;
            mst_err   <= 1'b0;
        end else if (srst) begin
            ptr       <= '0;
            grant     <= '0;
            counter   <= '0;
            slv_en    <= 1'b0;
            slv_wr    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_strb  <= '0;
            mst_ready <= '0;
            mst_rdata <= '0;
            mst_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant     <= win;
                        slv_en    <= 1'b1;
                        slv_wr    <= sel_wr;
                        slv_addr  <= sel_addr;
                        slv_wdata <= sel_wdata;
                        slv_strb  <= sel_strb;
                    end
                end
                ACCESS: begin
                    counter <= counter + 1'b1;
                    // A ready arriving on the last allowed cycle still counts
                    if (slv_ready) begin
                        slv_en    <= 1'b0;
                        mst_rdata <= slv_rdata;
                        mst_err   <= 1'b0;
                        mst_ready <= NB_MST'(1) << grant;
                    end else if (timed_out) begin
                        slv_en    <= 1'b0;
                        mst_rdata <= '0;
                        mst_err   <= 1'b1;
                        mst_ready <= NB_MST'(1) << grant;
                    end
                end
                COMPLETE: begin
                    mst_ready <= '0;
                    mst_err   <= 1'b0;
                    counter   <= '0;
                    ptr       <= (grant == PTRW'(NB_MST - 1)) ?
                                 '0 : grant + 1'b1;
                end
                default: begin
                    slv_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_friscv_apb_arbiter.sv
// Directed bench for friscv_apb_arbiter: read, write, contention,
// timeout, ready/timeout collision and resets.
module tb_friscv_apb_arbiter;

    localparam int NB_MST  = 2;
    localparam int ADDRW   = 16;
    localparam int XLEN    = 32;
    localparam int TIMEOUT = 4;

    logic                     aclk = 1'b0;
    logic                     aresetn;
    logic                     srst;
    logic [NB_MST-1:0]        mst_en;
    logic [NB_MST-1:0]        mst_wr;
    logic [NB_MST*ADDRW-1:0]  mst_addr;
    logic [NB_MST*XLEN-1:0]   mst_wdata;
    logic [NB_MST*XLEN/8-1:0] mst_strb;
    logic [NB_MST-1:0]        mst_ready;
    logic [XLEN-1:0]          mst_rdata;
    logic                     mst_err;
    logic                     slv_en;
    logic                     slv_wr;
    logic [ADDRW-1:0]         slv_addr;
    logic [XLEN-1:0]          slv_wdata;
    logic [XLEN/8-1:0]        slv_strb;
    logic [XLEN-1:0]          slv_rdata;
    logic                     slv_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    friscv_apb_arbiter #(
        .NB_MST  (NB_MST),
        .ADDRW   (ADDRW),
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .mst_en    (mst_en),
        .mst_wr    (mst_wr),
        .mst_addr  (mst_addr),
        .mst_wdata (mst_wdata),
        .mst_strb  (mst_strb),
        .mst_ready (mst_ready),
        .mst_rdata (mst_rdata),
        .mst_err   (mst_err),
        .slv_en    (slv_en),
        .slv_wr    (slv_wr),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_strb  (slv_strb),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr,
                           input logic [ADDRW-1:0] addr,
                           input logic [XLEN-1:0] wdata,
                           input logic [XLEN/8-1:0] strb);
        mst_wr[i]                 = wr;
        mst_addr[i*ADDRW +: ADDRW] = addr;
        mst_wdata[i*XLEN +: XLEN]  = wdata;
        mst_strb[i*4 +: 4]         = strb;
    endtask

    initial begin
        aresetn   = 1'b0;
        srst      = 1'b0;
        mst_en    = '0;
        mst_wr    = '0;
        mst_addr  = '0;
        mst_wdata = '0;
        mst_strb  = '0;
        slv_ready = 1'b0;
        slv_rdata = '0;
        #3;
        chk("rst_slv_en", slv_en, 0);
        chk("rst_ready", mst_ready, 0);
        chk("rst_rdata", mst_rdata, 0);
        chk("rst_err", mst_err, 0);
        chk("rst_addr", slv_addr, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        tick();

        // single read by requester 0
        set_req(0, 1'b0, 16'h0008, 32'h0, 4'h0);
        mst_en = 2'b01;
        tick();
        chk("rd_en1", slv_en, 1);
        chk("rd_addr", slv_addr, 16'h0008);
        chk("rd_wr", slv_wr, 0);
        chk("rd_rdy1", mst_ready, 0);
        tick();
        chk("rd_en2", slv_en, 1);
        slv_ready = 1'b1;
        slv_rdata = 32'h0000_1234;
        tick();
        slv_ready = 1'b0;
        chk("rd_ready", mst_ready, 2'b01);
        chk("rd_data", mst_rdata, 32'h1234);
        chk("rd_err", mst_err, 0);
        chk("rd_en3", slv_en, 0);
        mst_en = 2'b00;
        tick();
        chk("rd_pulse", mst_ready, 0);
        chk("rd_hold", mst_rdata, 32'h1234);

        // single write by requester 1
        set_req(1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF);
        mst_en = 2'b10;
        tick();
        chk("wr_en", slv_en, 1);
        chk("wr_wr", slv_wr, 1);
        chk("wr_addr", slv_addr, 16'h0010);
        chk("wr_wdata", slv_wdata, 32'hDEAD_BEEF);
        chk("wr_strb", slv_strb, 4'hF);
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        chk("wr_ready", mst_ready, 2'b10);
        mst_en = 2'b00;
        tick();
        chk("wr_pulse", mst_ready, 0);

        // contention from reset, both held
        #1 aresetn = 1'b0;
        #1 aresetn = 1'b1;
        set_req(0, 1'b0, 16'h0100, 32'h0, 4'h0);
        set_req(1, 1'b0, 16'h0200, 32'h0, 4'h0);
        mst_en = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ct_en", slv_en, 1);
            chk("ct_addr", slv_addr, (k % 2 == 0) ? 16'h0100 : 16'h0200);
            slv_ready = 1'b1;
            slv_rdata = 32'hA0 + 32'(k);
            tick();
            slv_ready = 1'b0;
            chk("ct_grant", mst_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("ct_data", mst_rdata, 32'hA0 + 32'(k));
            if (k == 3) mst_en = 2'b00;
            tick();
            chk("ct_idle", slv_en, 0);
        end

        // timeout, slave never ready
        set_req(0, 1'b0, 16'h0008, 32'h0, 4'h0);
        mst_en = 2'b01;
        for (int c = 0; c < TIMEOUT; c++) begin
            tick();
            chk("to_en", slv_en, 1);
        end
        tick();
        chk("to_en_off", slv_en, 0);
        chk("to_ready", mst_ready, 2'b01);
        chk("to_err", mst_err, 1);
        chk("to_rdata", mst_rdata, 0);
        mst_en = 2'b00;
        tick();
        chk("to_pulse", mst_ready, 0);
        chk("to_err_clr", mst_err, 0);
        tick();
        chk("to_idle", slv_en, 0);

        // ready arrives in the last allowed cycle
        set_req(1, 1'b0, 16'h000C, 32'h0, 4'h0);
        mst_en = 2'b10;
        for (int c = 0; c < TIMEOUT; c++) begin
            tick();
            chk("co_en", slv_en, 1);
        end
        slv_ready = 1'b1;
        slv_rdata = 32'hCAFE_0001;
        tick();
        slv_ready = 1'b0;
        chk("co_ready", mst_ready, 2'b10);
        chk("co_err", mst_err, 0);
        chk("co_data", mst_rdata, 32'hCAFE_0001);
        mst_en = 2'b00;
        tick();
        tick();

        // asynchronous reset during ACCESS
        set_req(0, 1'b0, 16'h0020, 32'h0, 4'h0);
        mst_en = 2'b01;
        tick();
        chk("ar_en", slv_en, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("ar_en_off", slv_en, 0);
        chk("ar_addr", slv_addr, 0);
        chk("ar_rdata", mst_rdata, 0);
        chk("ar_ready", mst_ready, 0);
        mst_en = 2'b00;
        tick();
        chk("ar_ready2", mst_ready, 0);
        aresetn = 1'b1;
        set_req(1, 1'b0, 16'h0044, 32'h0, 4'h0);
        mst_en = 2'b10;
        tick();
        chk("ar_new_en", slv_en, 1);
        chk("ar_new_addr", slv_addr, 16'h0044);
        slv_ready = 1'b1;
        slv_rdata = 32'h55;
        tick();
        slv_ready = 1'b0;
        chk("ar_new_rdy", mst_ready, 2'b10);
        chk("ar_new_data", mst_rdata, 32'h55);
        mst_en = 2'b00;
        tick();

        // synchronous reset during ACCESS restores ptr to 0
        set_req(0, 1'b0, 16'h0100, 32'h0, 4'h0);
        set_req(1, 1'b0, 16'h0200, 32'h0, 4'h0);
        mst_en = 2'b01;
        tick();
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        chk("sr_pre", mst_ready, 2'b01);
        mst_en = 2'b00;
        tick();
        mst_en = 2'b10;
        tick();
        chk("sr_acc", slv_addr, 16'h0200);
        srst = 1'b1;
        mst_en = 2'b00;
        tick();
        srst = 1'b0;
        chk("sr_en_off", slv_en, 0);
        chk("sr_ready", mst_ready, 0);
        tick();
        chk("sr_ready2", mst_ready, 0);
        mst_en = 2'b11;
        tick();
        chk("sr_ptr", slv_addr, 16'h0100);
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        chk("sr_grant", mst_ready, 2'b01);
        mst_en = 2'b00;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
